id_hazard_ctrl: RTL
===================

// Module: id_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the decode stage. Keeps a load scoreboard of pending GPR writes.
//  Stalls ID on load-use/WAW hazards, squashes ID on a taken branch, and drains the pipe around ecall.
//  Sits beside decodeMod: consumes decoded register fields, drives the ID stall/flush and the ecall handshake.
// PARAMETERS
//  NREGS         32  number of GPRs tracked (x0 never busy)
//  DRAIN_CYCLES  3   cycles after scoreboard empties before ecall_req (lets EX/MEM/WB retire untracked ops)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-high
//  id_valid      in   1   ID holds a valid instruction this cycle
//  id_rs1        in   5   source reg 1 index
//  id_rs1_used   in   1   instruction reads rs1
//  id_rs2        in   5   source reg 2 index
//  id_rs2_used   in   1   instruction reads rs2
//  id_rd         in   5   destination reg index
//  id_is_load    in   1   instruction is lb/lh/lw/ld/lbu/lhu/lwu
//  id_is_ecall   in   1   instruction is ecall
//  ex_branch     in   1   EX resolved taken branch/jump this cycle
//  wb_valid      in   1   load writeback this cycle
//  wb_rd         in   5   load writeback destination
//  ecall_done    in   1   ecall service complete (1-cycle pulse)
//  id_stall      out  1   hold IF/ID (combinational)
//  id_flush      out  1   replace ID instruction with NOP 32'h00000013 (combinational)
//  id_issue      out  1   ID instruction advances to EX this cycle (combinational)
//  ecall_req     out  1   registered; request ecall service
//  busy_map      out  NREGS registered scoreboard
//  state         out  2   registered FSM state (debug)
// BEHAVIOUR
//  Reset: busy_map=0, ecall_req=0, state=RUN, drain counter=0; reset mid-operation abandons any ecall, no done wait.
//  Effective busy: eb = busy_map & ~(wb_valid ? onehot(wb_rd) : 0); WB clear is visible same cycle.
//  Hazard (RUN): id_valid & ((rs1_used & rs1!=0 & eb[rs1]) | (rs2_used & rs2!=0 & eb[rs2]) | (id_is_load & rd!=0 & eb[rd])).
//  id_flush = ex_branch (any state); flush overrides stall; flushed instr never issues, never sets busy, never starts ecall.
//  id_stall = !ex_branch & (hazard | state!=RUN).
//  id_issue = id_valid & state==RUN & !hazard & !ex_branch.
//  Scoreboard next: clear bit wb_rd on wb_valid; then set bit id_rd on id_issue & id_is_load & id_rd!=0; set wins on same reg.
//  busy_map[0] is constant 0; wb_valid with wb_rd==0 or wb to a non-busy reg is a no-op.
//  FSM:
//   RUN   : id_issue & id_is_ecall -> DRAIN; load drain counter = DRAIN_CYCLES.
//   DRAIN : counter decrements to 0 (saturates); when counter==0 & busy_map==0 -> CALL; ecall_req<=1.
//   CALL  : ecall_req held 1; ecall_done -> RUN, ecall_req<=0 same edge.
//  ecall_done outside CALL is ignored. ex_branch in DRAIN/CALL flushes ID but does not abort the ecall.
//  Latency: ecall issue -> ecall_req high >= DRAIN_CYCLES+1 cycles; ecall_done -> id_stall low next cycle.
//  Counter width $clog2(DRAIN_CYCLES+1); DRAIN_CYCLES=0 allowed (CALL as soon as scoreboard empty).
// STRUCTURE
//  Package id_ctrl_pkg: typedef enum logic[1:0] {RUN=0, DRAIN=1, CALL=2} id_ctrl_state_t;
//   localparam NOP_INSTR = 32'h00000013; localparam REG_X0 = 5'd0.
//  Sub-module id_scoreboard: busy_map register, set/clear ports, eb output. FSM, counter, stall logic in top.
// TESTING
//  1 issue lw x5; next add x6,x5,x1 -> id_stall=1 until cycle of wb_valid,wb_rd=5; issue that cycle; busy_map=0 after.
//  2 issue lw x0 -> busy_map stays 0; dependent add x1,x0,x0 issues with no stall.
//  3 add stalled on busy x7 & ex_branch=1 -> id_flush=1, id_stall=0, id_issue=0; busy_map unchanged.
//  4 lw x7 outstanding, issue ecall -> DRAIN; wb x7 at +5 -> ecall_req=1 at +6 (counter already 0); ecall_done -> RUN next.
//  5 same cycle wb_valid,wb_rd=5 and issue lw x5 -> busy_map[5]=1 after edge.
//  6 reset asserted in CALL -> next cycle ecall_req=0, state=RUN, busy_map=0; late ecall_done ignored.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : id_ctrl_pkg                                               |
// | Purpose  : Shared types and constants for the ID hazard controller.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package id_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CALL  = 2'd2
  } id_ctrl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  REG_X0    = 5'd0;

  // x0 is hardwired to zero, so it never creates or resolves a dependency
  function automatic logic is_live_reg(input logic [4:0] idx);
    return idx != REG_X0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : id_hazard_ctrl_if                                         |
// | Purpose  : Decode-side signal bundle of the ID hazard controller.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface id_hazard_ctrl_if #(
  parameter int NREGS = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic             id_rs1_used;
  logic [4:0]       id_rs2;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_is_load;
  logic             id_is_ecall;
  logic             ex_branch;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             ecall_done;
  logic             id_stall;
  logic             id_flush;
  logic             id_issue;
  logic             ecall_req;
  logic [NREGS-1:0] busy_map;
  logic [1:0]       state;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
           id_is_load, id_is_ecall, ex_branch, wb_valid, wb_rd, ecall_done,
    input  id_stall, id_flush, id_issue, ecall_req, busy_map, state
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
           id_is_load, id_is_ecall, ex_branch, wb_valid, wb_rd, ecall_done,
    output id_stall, id_flush, id_issue, ecall_req, busy_map, state
  );

endinterface
`default_nettype wire

// File: rtl/id_hazard_ctrl_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : id_scoreboard                                             |
// | Purpose  : Pending-load GPR scoreboard with same-cycle WB bypass.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module id_scoreboard
  import id_ctrl_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_set,
  input  wire logic [4:0]       i_set_rd,
  input  wire logic             i_clr,
  input  wire logic [4:0]       i_clr_rd,
  output logic      [NREGS-1:0] o_busy_map,
  output logic      [NREGS-1:0] o_eb
);

  logic [NREGS-1:0] r_busy_map;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_busy_nxt;

  // Clear is applied before set so a reload of the retiring register stays busy
  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    if (i_clr) begin
      w_clr_mask[i_clr_rd] = 1'b1;
    end
    if (i_set && is_live_reg(i_set_rd)) begin
      w_set_mask[i_set_rd] = 1'b1;
    end
    w_busy_nxt    = (r_busy_map & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_map <= '0;
    end else begin
      r_busy_map <= w_busy_nxt;
    end
  end

  assign o_busy_map = r_busy_map;
  assign o_eb       = r_busy_map & ~w_clr_mask;

endmodule
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : id_hazard_ctrl                                            |
// | Purpose  : ID-stage stall/flush control and ecall drain sequencing.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module id_hazard_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input wire logic        clk,
  input wire logic        reset,
  id_hazard_ctrl_if.slave bus
);

  localparam int               CNT_W    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

  id_ctrl_state_t   r_state;
  id_ctrl_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ecall_req;
  logic             w_ecall_req_nxt;

  logic [NREGS-1:0] w_busy_map;
  logic [NREGS-1:0] w_eb;
  logic             w_run;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_waw_haz;
  logic             w_hazard;
  logic             w_issue;

  id_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set      (w_issue & bus.id_is_load),
    .i_set_rd   (bus.id_rd),
    .i_clr      (bus.wb_valid),
    .i_clr_rd   (bus.wb_rd),
    .o_busy_map (w_busy_map),
    .o_eb       (w_eb)
  );

  assign w_run     = (r_state == RUN);
  assign w_rs1_haz = bus.id_rs1_used && is_live_reg(bus.id_rs1) && w_eb[bus.id_rs1];
  assign w_rs2_haz = bus.id_rs2_used && is_live_reg(bus.id_rs2) && w_eb[bus.id_rs2];
  assign w_waw_haz = bus.id_is_load  && is_live_reg(bus.id_rd)  && w_eb[bus.id_rd];
  assign w_hazard  = w_run && bus.id_valid && (w_rs1_haz || w_rs2_haz || w_waw_haz);

  // A taken branch squashes ID outright, so it masks both stall and issue
  assign w_issue      = bus.id_valid && w_run && !w_hazard && !bus.ex_branch;
  assign bus.id_flush = bus.ex_branch;
  assign bus.id_stall = !bus.ex_branch && (w_hazard || !w_run);
  assign bus.id_issue = w_issue;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ecall_req_nxt = r_ecall_req;
    case (r_state)
      RUN: begin
        if (w_issue && bus.id_is_ecall) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      DRAIN: begin
        // Same-cycle WB counts as retired so the request is not delayed a cycle
        if ((r_cnt == '0) && (w_eb == '0)) begin
          w_state_nxt     = CALL;
          w_ecall_req_nxt = 1'b1;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      CALL: begin
        if (bus.ecall_done) begin
          w_state_nxt     = RUN;
          w_ecall_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_cnt_nxt       = '0;
        w_ecall_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_ecall_req <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ecall_req <= w_ecall_req_nxt;
    end
  end

  assign bus.ecall_req = r_ecall_req;
  assign bus.busy_map  = w_busy_map;
  assign bus.state     = r_state;

endmodule
`default_nettype wire
